// File: rtl/axi_rd_arbiter_pkg.sv
// Purpose: shared types and constants for the AXI read arbiter (FSM states, AXI ids, icache arsize).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_rd_arbiter_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [3:0] ID_ICACHE = 4'd0;
    localparam logic [3:0] ID_DCACHE = 4'd1;

    // icache refills are always full 32-bit words
    localparam logic [2:0] IC_ARSIZE = 3'd2;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Purpose: bundles both requester ports and the AXI AR/R channel pair of the read arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; slave = arbiter view, master = requesters plus AXI bridge view.
interface axi_rd_arbiter_if
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
);
    // icache requester
    logic              ic_rd_req;
    logic [ADDR_W-1:0] ic_rd_addr;
    logic [LEN_W-1:0]  ic_rd_len;
    logic              ic_rd_ack;
    logic              ic_ret_valid;
    logic              ic_ret_last;
    // dcache / uncached requester
    logic              dc_rd_req;
    logic [ADDR_W-1:0] dc_rd_addr;
    logic [LEN_W-1:0]  dc_rd_len;
    logic [2:0]        dc_rd_size;
    logic              dc_rd_ack;
    logic              dc_ret_valid;
    logic              dc_ret_last;
    logic              wr_pending;
    // shared return data
    logic [DATA_W-1:0] ret_data;
    // AXI AR
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [3:0]        arid;
    logic              arready;
    // AXI R
    logic              rvalid;
    logic              rready;
    logic [3:0]        rid;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    // status
    logic              proto_err;

    modport slave (
        input  ic_rd_req, ic_rd_addr, ic_rd_len,
        input  dc_rd_req, dc_rd_addr, dc_rd_len, dc_rd_size, wr_pending,
        input  arready, rvalid, rid, rdata, rlast,
        output ic_rd_ack, ic_ret_valid, ic_ret_last,
        output dc_rd_ack, dc_ret_valid, dc_ret_last,
        output ret_data, arvalid, araddr, arlen, arsize, arid, rready, proto_err
    );

    modport master (
        output ic_rd_req, ic_rd_addr, ic_rd_len,
        output dc_rd_req, dc_rd_addr, dc_rd_len, dc_rd_size, wr_pending,
        output arready, rvalid, rid, rdata, rlast,
        input  ic_rd_ack, ic_ret_valid, ic_ret_last,
        input  dc_rd_ack, dc_ret_valid, dc_ret_last,
        input  ret_data, arvalid, araddr, arlen, arsize, arid, rready, proto_err
    );

endinterface

// File: rtl/axi_rd_arbiter_pick.sv
// Purpose: winner selection between icache and dcache read requests (fixed dcache priority, or round-robin with AXI_RD_ARB_RR_EN).
// Latency: combinational.
// Backpressure: none; eligibility (wr_pending blocking) is applied by the caller.
module rd_arb_pick (
    input  logic ic_elig,
    input  logic dc_elig,
`ifdef AXI_RD_ARB_RR_EN
    input  logic last_dc,
`endif
    output logic gnt_vld,
    output logic gnt_dc
);

    // choose the winner; only contention depends on the variant
    always_comb begin
        gnt_vld = ic_elig | dc_elig;
`ifdef AXI_RD_ARB_RR_EN
        if (ic_elig && dc_elig) begin
            gnt_dc = !last_dc;
        end else begin
            gnt_dc = dc_elig;
        end
`else
        gnt_dc = dc_elig;
`endif
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Purpose: shares one AXI AR/R channel pair between icache (id 0) and dcache (id 1), one burst at a time; optional round-robin via AXI_RD_ARB_RR_EN.
// Latency: req to arvalid 1 cycle; ack combinational in the AR handshake cycle; R beats forwarded combinationally; 1 idle cycle after rlast.
// Backpressure: AR held stable until arready; rready held high for the whole burst, so R is never stalled.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int LEN_W  = AXI_LEN_W
) (
    input  logic               clk,
    input  logic               resetn,
    axi_rd_arbiter_if.slave    bus
);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  lat_addr;
    logic [LEN_W-1:0]   lat_len;
    logic [2:0]         lat_size;
    logic [3:0]         lat_id;
    logic [LEN_W:0]     beat_cnt;
    logic               proto_err_q;

    logic               ic_elig;
    logic               dc_elig;
    logic               gnt_vld;
    logic               gnt_dc;
    logic               grant;
    logic               ar_hs;
    logic               beat;
    logic               lat_is_dc;
    logic               beat_err;

    // a pending write must drain before the dcache may read (load-after-store ordering)
    assign ic_elig = bus.ic_rd_req;
    assign dc_elig = bus.dc_rd_req & ~bus.wr_pending;

`ifdef AXI_RD_ARB_RR_EN
    logic last_dc;

    rd_arb_pick u_pick (
        .ic_elig (ic_elig),
        .dc_elig (dc_elig),
        .last_dc (last_dc),
        .gnt_vld (gnt_vld),
        .gnt_dc  (gnt_dc)
    );

    // remember who won last so the other side wins the next contention
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_dc <= 1'b0;
        end else if (grant) begin
            last_dc <= gnt_dc;
        end
    end
`else
    rd_arb_pick u_pick (
        .ic_elig (ic_elig),
        .dc_elig (dc_elig),
        .gnt_vld (gnt_vld),
        .gnt_dc  (gnt_dc)
    );
`endif

    assign grant     = (state == ST_IDLE) && gnt_vld;
    assign ar_hs     = (state == ST_ADDR) && bus.arready;
    assign beat      = (state == ST_DATA) && bus.rvalid;
    assign lat_is_dc = (lat_id == ID_DCACHE);

    // beat_cnt holds the index of the beat currently on R
    assign beat_err = beat && ((bus.rid != lat_id) ||
                               ( bus.rlast && (beat_cnt != {1'b0, lat_len})) ||
                               (!bus.rlast && (beat_cnt >= {1'b0, lat_len})));

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: grant, AR handshake, last beat; IDLE always lasts at least one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (gnt_vld)                  state_nxt = ST_ADDR;
            ST_ADDR: if (bus.arready)              state_nxt = ST_DATA;
            ST_DATA: if (bus.rvalid && bus.rlast)  state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // capture the winner's request at grant; AR fields come only from here
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_addr <= '0;
            lat_len  <= '0;
            lat_size <= '0;
            lat_id   <= '0;
        end else if (grant) begin
            if (gnt_dc) begin
                lat_addr <= bus.dc_rd_addr;
                lat_len  <= bus.dc_rd_len;
                lat_size <= bus.dc_rd_size;
                lat_id   <= ID_DCACHE;
            end else begin
                lat_addr <= bus.ic_rd_addr;
                lat_len  <= bus.ic_rd_len;
                lat_size <= IC_ARSIZE;
                lat_id   <= ID_ICACHE;
            end
        end
    end

    // beat counter: cleared on AR handshake, saturates instead of wrapping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_cnt <= '0;
        end else if (ar_hs) begin
            beat_cnt <= '0;
        end else if (beat && (beat_cnt != '1)) begin
            beat_cnt <= beat_cnt + (LEN_W+1)'(1);
        end
    end

    // sticky protocol error; beats are still forwarded
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            proto_err_q <= 1'b0;
        end else if (beat_err) begin
            proto_err_q <= 1'b1;
        end
    end

    // AXI and requester outputs, routed by the latched grant id
    always_comb begin
        bus.arvalid      = (state == ST_ADDR);
        bus.araddr       = lat_addr;
        bus.arlen        = lat_len;
        bus.arsize       = lat_size;
        bus.arid         = lat_id;
        bus.rready       = (state == ST_DATA);
        bus.ic_rd_ack    = ar_hs && !lat_is_dc;
        bus.dc_rd_ack    = ar_hs &&  lat_is_dc;
        bus.ic_ret_valid = beat && !lat_is_dc;
        bus.dc_ret_valid = beat &&  lat_is_dc;
        bus.ic_ret_last  = beat && !lat_is_dc && bus.rlast;
        bus.dc_ret_last  = beat &&  lat_is_dc && bus.rlast;
        bus.ret_data     = beat ? bus.rdata : '0;
        bus.proto_err    = proto_err_q;
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Purpose: self-checking bench for axi_rd_arbiter (table vectors, directed corner sequences, randomized transactions).
// Latency: n/a.
// Backpressure: n/a.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) bus ();

    axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .LEN_W(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

`ifdef AXI_RD_ARB_RR_EN
    bit model_last_dc;
`endif

    typedef struct {
        bit ic;
        bit dc;
        bit wp;
        bit exp_vld;
        bit exp_dc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.ic_rd_req  = 1'b0;
        bus.ic_rd_addr = '0;
        bus.ic_rd_len  = '0;
        bus.dc_rd_req  = 1'b0;
        bus.dc_rd_addr = '0;
        bus.dc_rd_len  = '0;
        bus.dc_rd_size = '0;
        bus.wr_pending = 1'b0;
        bus.arready    = 1'b0;
        bus.rvalid     = 1'b0;
        bus.rid        = '0;
        bus.rdata      = '0;
        bus.rlast      = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
`ifdef AXI_RD_ARB_RR_EN
        model_last_dc = 1'b0;
`endif
        tick();
        tick();
        resetn = 1'b1;
    endtask

    // reference rule: dcache eligible only without pending writes; on contention
    // fixed build prefers dcache, round-robin prefers whoever did not win last
    function automatic int exp_winner(input bit ic, input bit dc, input bit wp);
        bit dce;
        dce = dc && !wp;
        if (ic && dce) begin
`ifdef AXI_RD_ARB_RR_EN
            return model_last_dc ? 0 : 1;
`else
            return 1;
`endif
        end
        if (dce) return 1;
        if (ic)  return 0;
        return -1;
    endfunction

    // called one cycle after grant: waits, then AR handshake with field checks
    task automatic ar_phase(input int waits, input bit exp_dc, input logic [31:0] a,
                            input logic [7:0] l, input logic [2:0] s, input string tag);
        for (int i = 0; i < waits; i++) begin
            bus.arready = 1'b0;
            #1;
            chk({tag, " arvalid hold"}, bus.arvalid, 1);
            chk({tag, " ack early"}, {bus.ic_rd_ack, bus.dc_rd_ack}, 0);
            tick();
        end
        bus.arready = 1'b1;
        #1;
        chk({tag, " arvalid"}, bus.arvalid, 1);
        chk({tag, " araddr"}, bus.araddr, a);
        chk({tag, " arlen"}, bus.arlen, l);
        chk({tag, " arsize"}, bus.arsize, s);
        chk({tag, " arid"}, bus.arid, exp_dc ? 4'd1 : 4'd0);
        chk({tag, " acks"}, {bus.ic_rd_ack, bus.dc_rd_ack}, exp_dc ? 2'b01 : 2'b10);
        chk({tag, " rready in addr"}, bus.rready, 0);
`ifdef AXI_RD_ARB_RR_EN
        model_last_dc = exp_dc;
`endif
        tick();
        bus.arready = 1'b0;
        if (exp_dc) bus.dc_rd_req = 1'b0;
        else        bus.ic_rd_req = 1'b0;
    endtask

    // nbeats beats with random gaps, rlast on the final one
    task automatic r_phase(input bit exp_dc, input logic [3:0] id, input int nbeats,
                           input int max_gap, input string tag);
        for (int b = 0; b < nbeats; b++) begin
            int gap;
            logic [31:0] d;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                bus.rvalid = 1'b0;
                bus.rlast  = 1'b0;
                #1;
                chk({tag, " rready gap"}, bus.rready, 1);
                chk({tag, " ret_valid gap"}, {bus.ic_ret_valid, bus.dc_ret_valid}, 0);
                tick();
            end
            d = $urandom;
            bus.rvalid = 1'b1;
            bus.rid    = id;
            bus.rdata  = d;
            bus.rlast  = (b == nbeats - 1);
            #1;
            chk({tag, " rready"}, bus.rready, 1);
            chk({tag, " ret_valid"}, {bus.ic_ret_valid, bus.dc_ret_valid}, exp_dc ? 2'b01 : 2'b10);
            chk({tag, " ret_data"}, bus.ret_data, d);
            chk({tag, " ret_last"}, {bus.ic_ret_last, bus.dc_ret_last},
                (b == nbeats - 1) ? (exp_dc ? 2'b01 : 2'b10) : 2'b00);
            tick();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        chk({tag, " arvalid idle"}, bus.arvalid, 0);
        chk({tag, " rready idle"}, bus.rready, 0);
    endtask

    initial begin
        int w;
        int ic_p;
        int dc_p;
        logic [31:0] ic_a;
        logic [31:0] dc_a;
        logic [7:0]  ic_l;
        logic [7:0]  dc_l;
        logic [2:0]  dc_s;

        idle_inputs();

        // ---------- reset state ----------
        do_reset();
        #1;
        chk("rst arvalid", bus.arvalid, 0);
        chk("rst rready", bus.rready, 0);
        chk("rst acks", {bus.ic_rd_ack, bus.dc_rd_ack}, 0);
        chk("rst ret", {bus.ic_ret_valid, bus.dc_ret_valid, bus.ic_ret_last, bus.dc_ret_last}, 0);
        chk("rst proto_err", bus.proto_err, 0);
        chk("rst araddr", bus.araddr, 0);
        chk("rst arlen", bus.arlen, 0);

        // ---------- table: single-cycle arbitration decisions after reset ----------
        vecs[0] = '{ic:1, dc:0, wp:0, exp_vld:1, exp_dc:0};
        vecs[1] = '{ic:0, dc:1, wp:0, exp_vld:1, exp_dc:1};
        vecs[2] = '{ic:1, dc:1, wp:0, exp_vld:1, exp_dc:1};
        vecs[3] = '{ic:0, dc:1, wp:1, exp_vld:0, exp_dc:0};
        vecs[4] = '{ic:1, dc:1, wp:1, exp_vld:1, exp_dc:0};
        vecs[5] = '{ic:0, dc:0, wp:0, exp_vld:0, exp_dc:0};
        vecs[6] = '{ic:0, dc:0, wp:1, exp_vld:0, exp_dc:0};
        for (int v = 0; v < 7; v++) begin
            do_reset();
            bus.ic_rd_req  = vecs[v].ic;
            bus.ic_rd_addr = 32'h1000_0000 + 32'(v * 16);
            bus.dc_rd_req  = vecs[v].dc;
            bus.dc_rd_addr = 32'h8000_0000 + 32'(v * 16);
            bus.dc_rd_size = 3'd1;
            bus.wr_pending = vecs[v].wp;
            #1;
            chk($sformatf("vec%0d arvalid in idle", v), bus.arvalid, 0);
            tick();
            #1;
            chk($sformatf("vec%0d arvalid", v), bus.arvalid, vecs[v].exp_vld);
            if (vecs[v].exp_vld) begin
                ar_phase(0, vecs[v].exp_dc,
                         vecs[v].exp_dc ? 32'h8000_0000 + 32'(v * 16) : 32'h1000_0000 + 32'(v * 16),
                         8'd0, vecs[v].exp_dc ? 3'd1 : 3'd2, $sformatf("vec%0d", v));
                r_phase(vecs[v].exp_dc, vecs[v].exp_dc ? 4'd1 : 4'd0, 1, 0, $sformatf("vec%0d", v));
            end
        end

        // ---------- icache alone, len 3, arready on 2nd cycle ----------
        do_reset();
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0000;
        bus.ic_rd_len  = 8'd3;
        #1;
        chk("ic1 arvalid before grant", bus.arvalid, 0);
        tick();
        ar_phase(1, 1'b0, 32'h1c00_0000, 8'd3, 3'd2, "ic1");
        r_phase(1'b0, 4'd0, 4, 0, "ic1");
        chk_idle("ic1");
        chk("ic1 proto_err", bus.proto_err, 0);

        // ---------- simultaneous pair: dcache first, icache after one idle cycle ----------
        do_reset();
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0100;
        bus.ic_rd_len  = 8'd1;
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_0040;
        bus.dc_rd_len  = 8'd0;
        bus.dc_rd_size = 3'd0;
        tick();
        ar_phase(0, 1'b1, 32'h8000_0040, 8'd0, 3'd0, "pair dc");
        r_phase(1'b1, 4'd1, 1, 0, "pair dc");
        chk_idle("pair bubble");
        chk("pair bubble ic ack", bus.ic_rd_ack, 0);
        tick();
        ar_phase(0, 1'b0, 32'h1c00_0100, 8'd1, 3'd2, "pair ic");
        r_phase(1'b0, 4'd0, 2, 1, "pair ic");

        // ---------- contention right after a dcache-only grant ----------
        do_reset();
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_0080;
        bus.dc_rd_size = 3'd2;
        tick();
        ar_phase(0, 1'b1, 32'h8000_0080, 8'd0, 3'd2, "rr pre");
        r_phase(1'b1, 4'd1, 1, 0, "rr pre");
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0200;
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_00c0;
        w = exp_winner(1'b1, 1'b1, 1'b0);
        tick();
        ar_phase(0, w == 1, (w == 1) ? 32'h8000_00c0 : 32'h1c00_0200, 8'd0, (w == 1) ? 3'd2 : 3'd2, "rr second");
        r_phase(w == 1, (w == 1) ? 4'd1 : 4'd0, 1, 0, "rr second");
        tick();
        ar_phase(0, w != 1, (w != 1) ? 32'h8000_00c0 : 32'h1c00_0200, 8'd0, 3'd2, "rr third");
        r_phase(w != 1, (w != 1) ? 4'd1 : 4'd0, 1, 0, "rr third");

        // ---------- wr_pending holds off a dcache read for 5 cycles ----------
        do_reset();
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_1000;
        bus.dc_rd_len  = 8'd1;
        bus.dc_rd_size = 3'd2;
        bus.wr_pending = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("wp block c%0d arvalid", i), bus.arvalid, 0);
            tick();
        end
        bus.wr_pending = 1'b0;
        #1;
        chk("wp fall arvalid", bus.arvalid, 0);
        tick();
        ar_phase(0, 1'b1, 32'h8000_1000, 8'd1, 3'd2, "wp grant");
        r_phase(1'b1, 4'd1, 2, 0, "wp grant");

        // ---------- early rlast on a len 3 burst ----------
        do_reset();
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0300;
        bus.ic_rd_len  = 8'd3;
        tick();
        ar_phase(0, 1'b0, 32'h1c00_0300, 8'd3, 3'd2, "early last");
        r_phase(1'b0, 4'd0, 2, 0, "early last");
        chk_idle("early last");
        chk("early last proto_err", bus.proto_err, 1);
        tick();
        tick();
        chk("early last proto_err held", bus.proto_err, 1);

        // ---------- wrong rid during an icache burst ----------
        do_reset();
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0400;
        tick();
        ar_phase(0, 1'b0, 32'h1c00_0400, 8'd0, 3'd2, "bad rid");
        #1;
        chk("bad rid proto_err before", bus.proto_err, 0);
        r_phase(1'b0, 4'd1, 1, 0, "bad rid");
        #1;
        chk("bad rid proto_err", bus.proto_err, 1);

        // ---------- reset during DATA after 2 beats (proto_err still set) ----------
        bus.ic_rd_req  = 1'b1;
        bus.ic_rd_addr = 32'h1c00_0500;
        bus.ic_rd_len  = 8'd3;
        tick();
        ar_phase(0, 1'b0, 32'h1c00_0500, 8'd3, 3'd2, "mid rst");
        for (int b = 0; b < 2; b++) begin
            bus.rvalid = 1'b1;
            bus.rid    = 4'd0;
            bus.rdata  = 32'(b + 1);
            bus.rlast  = 1'b0;
            tick();
        end
        bus.rdata = 32'hdead_beef;
        #1;
        chk("mid rst beat3 valid", bus.ic_ret_valid, 1);
        resetn = 1'b0;
        #1;
        chk("mid rst arvalid", bus.arvalid, 0);
        chk("mid rst rready", bus.rready, 0);
        chk("mid rst ret", {bus.ic_ret_valid, bus.dc_ret_valid, bus.ic_ret_last, bus.dc_ret_last}, 0);
        chk("mid rst ret_data", bus.ret_data, 0);
        chk("mid rst proto_err", bus.proto_err, 0);
        chk("mid rst araddr", bus.araddr, 0);
        do_reset();
        bus.dc_rd_req  = 1'b1;
        bus.dc_rd_addr = 32'h8000_2000;
        bus.dc_rd_len  = 8'd2;
        bus.dc_rd_size = 3'd2;
        tick();
        ar_phase(0, 1'b1, 32'h8000_2000, 8'd2, 3'd2, "post rst");
        r_phase(1'b1, 4'd1, 3, 1, "post rst");
        #1;
        chk("post rst proto_err", bus.proto_err, 0);

        // ---------- randomized transactions against the reference rules ----------
        do_reset();
        ic_p = 0;
        dc_p = 0;
        ic_a = '0;
        dc_a = '0;
        ic_l = '0;
        dc_l = '0;
        dc_s = '0;
        for (int it = 0; it < 60; it++) begin
            if (ic_p == 0 && $urandom_range(1, 0) == 1) begin
                ic_p = 1;
                ic_a = $urandom & 32'hffff_fffc;
                ic_l = 8'($urandom_range(7, 0));
            end
            if (dc_p == 0 && $urandom_range(1, 0) == 1) begin
                dc_p = 1;
                dc_a = $urandom;
                dc_l = 8'($urandom_range(7, 0));
                dc_s = 3'($urandom_range(2, 0));
            end
            bus.ic_rd_req  = (ic_p != 0);
            bus.ic_rd_addr = ic_a;
            bus.ic_rd_len  = ic_l;
            bus.dc_rd_req  = (dc_p != 0);
            bus.dc_rd_addr = dc_a;
            bus.dc_rd_len  = dc_l;
            bus.dc_rd_size = dc_s;
            bus.wr_pending = ($urandom_range(3, 0) == 0);
            w = exp_winner(ic_p != 0, dc_p != 0, bus.wr_pending);
            #1;
            chk($sformatf("rnd%0d idle arvalid", it), bus.arvalid, 0);
            tick();
            if (w < 0) begin
                #1;
                chk($sformatf("rnd%0d no grant", it), bus.arvalid, 0);
                continue;
            end
            if (w == 1) begin
                ar_phase(int'($urandom_range(2, 0)), 1'b1, dc_a, dc_l, dc_s, $sformatf("rnd%0d", it));
                dc_p = 0;
                r_phase(1'b1, 4'd1, int'(dc_l) + 1, 2, $sformatf("rnd%0d", it));
            end else begin
                ar_phase(int'($urandom_range(2, 0)), 1'b0, ic_a, ic_l, 3'd2, $sformatf("rnd%0d", it));
                ic_p = 0;
                r_phase(1'b0, 4'd0, int'(ic_l) + 1, 2, $sformatf("rnd%0d", it));
            end
            #1;
            chk($sformatf("rnd%0d proto_err", it), bus.proto_err, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
